// File: rtl/us_sensors.sv
// Four-channel PING-style ultrasonic ranging controller: triggers each sensor in turn,
// converts echo width to cm, publishes on a slow strobe and derives side-wall angle.
module us_sensors #(
  parameter int TRIG_TICKS      = 250,
  parameter int ECHO_WAIT_TICKS = 50000,
  parameter int CM_TICKS        = 2900,
  parameter int ECHO_MAX_TICKS  = 1000000,
  parameter int GAP_TICKS       = 10000
) (
  input  logic       CLK,
  input  logic       RST_N,
  inout  wire        SIG1,
  inout  wire        SIG2,
  inout  wire        SIG3,
  inout  wire        SIG4,
  input  logic       SCLK_50MHz,
  input  logic       DEBOUCED_SCLK,
  output logic [7:0] ANGLE,
  output logic [1:0] ANGLE_DIRECTION,
  output logic [7:0] DISTANCE1_DEBOUNCED,
  output logic [7:0] DISTANCE2_DEBOUNCED,
  output logic [7:0] DISTANCE3_DEBOUNCED,
  output logic [7:0] DISTANCE4_DEBOUNCED
);

  localparam int MAX_A = (TRIG_TICKS > GAP_TICKS) ? TRIG_TICKS : GAP_TICKS;
  localparam int MAX_B = (ECHO_WAIT_TICKS > ECHO_MAX_TICKS) ? ECHO_WAIT_TICKS : ECHO_MAX_TICKS;
  localparam int MAX_T = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CW    = (MAX_T > 1) ? $clog2(MAX_T) : 1;
  localparam int CMW   = (CM_TICKS > 1) ? $clog2(CM_TICKS) : 1;

  localparam logic [CW-1:0]  GAP_LAST  = CW'(GAP_TICKS - 1);
  localparam logic [CW-1:0]  TRIG_LAST = CW'(TRIG_TICKS - 1);
  localparam logic [CW-1:0]  WAIT_LAST = CW'(ECHO_WAIT_TICKS - 1);
  localparam logic [CW-1:0]  MAX_LAST  = CW'(ECHO_MAX_TICKS - 1);
  localparam logic [CMW-1:0] CM_LAST   = CMW'(CM_TICKS - 1);

  typedef enum logic [2:0] {S_GAP, S_TRIG, S_WAIT_RISE, S_MEASURE, S_DONE} state_t;

  state_t         r_state;
  logic [1:0]     r_idx;
  logic [CW-1:0]  r_tick;
  logic [CMW-1:0] r_cmTick;
  logic [7:0]     r_cm;
  logic [7:0]     r_result;
  logic           r_armed;
  logic [3:0]     r_drive;
  logic [7:0]     r_raw [4];
  logic [3:0]     r_sigSync1;
  logic [3:0]     r_sigSync2;
  logic [1:0]     r_sclk;
  logic [1:0]     r_dsclk;

  logic [3:0] w_sigIn;
  logic       w_tick;
  logic       w_pub;
  logic       w_echo;
  logic [7:0] w_d1;
  logic [7:0] w_d2;
  logic [7:0] w_angle;
  logic [1:0] w_dir;

  assign SIG1 = r_drive[0] ? 1'b1 : 1'bz;
  assign SIG2 = r_drive[1] ? 1'b1 : 1'bz;
  assign SIG3 = r_drive[2] ? 1'b1 : 1'bz;
  assign SIG4 = r_drive[3] ? 1'b1 : 1'bz;

  assign w_sigIn = {SIG4, SIG3, SIG2, SIG1};
  assign w_tick  = r_sclk[0] & ~r_sclk[1];
  assign w_pub   = r_dsclk[0] & ~r_dsclk[1];
  assign w_echo  = r_sigSync2[r_idx];
  assign w_d1    = r_raw[0];
  assign w_d2    = r_raw[1];

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_sigSync1 <= '0;
      r_sigSync2 <= '0;
      r_sclk     <= '0;
      r_dsclk    <= '0;
    end else begin
      r_sigSync1 <= w_sigIn;
      r_sigSync2 <= r_sigSync1;
      r_sclk     <= {r_sclk[0], SCLK_50MHz};
      r_dsclk    <= {r_dsclk[0], DEBOUCED_SCLK};
    end
  end

  // The synchronizer still shows our own trigger for a couple of cycles after release,
  // so an echo rise only counts once the line has been seen low (r_armed).
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state  <= S_GAP;
      r_idx    <= '0;
      r_tick   <= '0;
      r_cmTick <= '0;
      r_cm     <= '0;
      r_result <= '0;
      r_armed  <= 1'b0;
      r_drive  <= '0;
      for (int i = 0; i < 4; i++) r_raw[i] <= '0;
    end else begin
      case (r_state)
        S_GAP: begin
          if (w_tick) begin
            if (r_tick == GAP_LAST) begin
              r_tick  <= '0;
              r_drive <= 4'b0001 << r_idx;
              r_state <= S_TRIG;
            end else begin
              r_tick <= r_tick + 1'b1;
            end
          end
        end
        S_TRIG: begin
          if (w_tick) begin
            if (r_tick == TRIG_LAST) begin
              r_tick  <= '0;
              r_drive <= '0;
              r_armed <= 1'b0;
              r_state <= S_WAIT_RISE;
            end else begin
              r_tick <= r_tick + 1'b1;
            end
          end
        end
        S_WAIT_RISE: begin
          if (!w_echo) r_armed <= 1'b1;
          if (w_echo && r_armed) begin
            r_tick   <= '0;
            r_cmTick <= '0;
            r_cm     <= '0;
            r_state  <= S_MEASURE;
          end else if (w_tick) begin
            if (r_tick == WAIT_LAST) begin
              r_result <= 8'hFF;
              r_state  <= S_DONE;
            end else begin
              r_tick <= r_tick + 1'b1;
            end
          end
        end
        S_MEASURE: begin
          if (!w_echo) begin
            r_result <= r_cm;
            r_state  <= S_DONE;
          end else if (w_tick) begin
            if (r_tick == MAX_LAST) begin
              r_result <= 8'hFF;
              r_state  <= S_DONE;
            end else begin
              r_tick <= r_tick + 1'b1;
            end
            if (r_cmTick == CM_LAST) begin
              r_cmTick <= '0;
              if (r_cm != 8'hFF) r_cm <= r_cm + 1'b1;
            end else begin
              r_cmTick <= r_cmTick + 1'b1;
            end
          end
        end
        S_DONE: begin
          r_raw[r_idx] <= r_result;
          r_idx        <= r_idx + 1'b1;
          r_tick       <= '0;
          r_state      <= S_GAP;
        end
        default: begin
          r_state <= S_GAP;
          r_drive <= '0;
        end
      endcase
    end
  end

  // A 255 on either side sensor means no usable reading, so the angle is flagged invalid.
  always_comb begin
    w_angle = '0;
    w_dir   = 2'b00;
    if (w_d1 == 8'hFF || w_d2 == 8'hFF) begin
      w_dir = 2'b11;
    end else if (w_d2 > w_d1) begin
      w_angle = w_d2 - w_d1;
      w_dir   = 2'b01;
    end else if (w_d1 > w_d2) begin
      w_angle = w_d1 - w_d2;
      w_dir   = 2'b10;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      DISTANCE1_DEBOUNCED <= '0;
      DISTANCE2_DEBOUNCED <= '0;
      DISTANCE3_DEBOUNCED <= '0;
      DISTANCE4_DEBOUNCED <= '0;
      ANGLE               <= '0;
      ANGLE_DIRECTION     <= '0;
    end else if (w_pub) begin
      DISTANCE1_DEBOUNCED <= r_raw[0];
      DISTANCE2_DEBOUNCED <= r_raw[1];
      DISTANCE3_DEBOUNCED <= r_raw[2];
      DISTANCE4_DEBOUNCED <= r_raw[3];
      ANGLE               <= w_angle;
      ANGLE_DIRECTION     <= w_dir;
    end
  end

endmodule

// File: tb/tb_us_sensors.sv
// Self-checking bench for us_sensors: a behavioural sensor model answers triggers with
// randomized echo widths and published distances/angle are compared to arithmetic expectations.
module tb_us_sensors;

  localparam int TRIG   = 5;
  localparam int EWAIT  = 100;
  localparam int CM     = 4;
  localparam int EMAX   = 1200;
  localparam int GAP    = 40;
  localparam int RDLY   = 10;
  localparam int BUDGET = 20000;

  logic CLK = 1'b0;
  logic RST_N = 1'b0;
  logic SCLK_50MHz = 1'b0;
  logic DEBOUCED_SCLK = 1'b0;
  wire  SIG1, SIG2, SIG3, SIG4;
  logic [7:0] ANGLE;
  logic [1:0] ANGLE_DIRECTION;
  logic [7:0] DISTANCE1_DEBOUNCED, DISTANCE2_DEBOUNCED, DISTANCE3_DEBOUNCED, DISTANCE4_DEBOUNCED;

  logic [3:0] echoDrv = '0;
  int echoW [4] = '{0, 0, 0, 0};
  int trigOrder [$];
  int trigWidth [$];
  int mState = 0;
  int mIdx = 0;
  int mCnt = 0;
  int mWidth = 0;
  int total = 0;
  int bad = 0;

  pulldown pd1 (SIG1);
  pulldown pd2 (SIG2);
  pulldown pd3 (SIG3);
  pulldown pd4 (SIG4);
  assign SIG1 = echoDrv[0] ? 1'b1 : 1'bz;
  assign SIG2 = echoDrv[1] ? 1'b1 : 1'bz;
  assign SIG3 = echoDrv[2] ? 1'b1 : 1'bz;
  assign SIG4 = echoDrv[3] ? 1'b1 : 1'bz;

  us_sensors #(
    .TRIG_TICKS(TRIG), .ECHO_WAIT_TICKS(EWAIT), .CM_TICKS(CM),
    .ECHO_MAX_TICKS(EMAX), .GAP_TICKS(GAP)
  ) dut (
    .CLK(CLK), .RST_N(RST_N),
    .SIG1(SIG1), .SIG2(SIG2), .SIG3(SIG3), .SIG4(SIG4),
    .SCLK_50MHz(SCLK_50MHz), .DEBOUCED_SCLK(DEBOUCED_SCLK),
    .ANGLE(ANGLE), .ANGLE_DIRECTION(ANGLE_DIRECTION),
    .DISTANCE1_DEBOUNCED(DISTANCE1_DEBOUNCED), .DISTANCE2_DEBOUNCED(DISTANCE2_DEBOUNCED),
    .DISTANCE3_DEBOUNCED(DISTANCE3_DEBOUNCED), .DISTANCE4_DEBOUNCED(DISTANCE4_DEBOUNCED)
  );

  always #5 CLK = ~CLK;
  always #10 SCLK_50MHz = ~SCLK_50MHz;

  function automatic logic lineVal(input int n);
    case (n)
      0: return SIG1;
      1: return SIG2;
      2: return SIG3;
      default: return SIG4;
    endcase
  endfunction

  function automatic logic [7:0] distOut(input int n);
    case (n)
      0: return DISTANCE1_DEBOUNCED;
      1: return DISTANCE2_DEBOUNCED;
      2: return DISTANCE3_DEBOUNCED;
      default: return DISTANCE4_DEBOUNCED;
    endcase
  endfunction

  // Expected reading for an echo of w ticks (0 = sensor never answers).
  function automatic int expCm(input int w);
    if (w == 0 || w >= EMAX) return 255;
    if (w / CM > 255) return 255;
    return w / CM;
  endfunction

  function automatic void expAngle(input int d1, input int d2, output int a, output int dir);
    if (d1 == 255 || d2 == 255) begin a = 0; dir = 3; end
    else if (d1 == d2) begin a = 0; dir = 0; end
    else if (d2 > d1) begin a = d2 - d1; dir = 1; end
    else begin a = d1 - d2; dir = 2; end
  endfunction

  function automatic int randW();
    return $urandom_range(1, 60) * CM + CM / 2;
  endfunction

  // Sensor model: sees a trigger, waits RDLY ticks after release, then echoes echoW ticks.
  initial begin : sensorModel
    forever begin
      @(negedge CLK);
      if (!RST_N) begin
        echoDrv = '0;
        mState  = 0;
      end else begin
        case (mState)
          0: begin
            for (int n = 0; n < 4; n++) begin
              if (mState == 0 && lineVal(n) === 1'b1) begin
                mState = 1;
                mIdx   = n;
                mWidth = 1;
                trigOrder.push_back(n + 1);
              end
            end
          end
          1: begin
            if (lineVal(mIdx) === 1'b1) mWidth++;
            else begin
              trigWidth.push_back(mWidth);
              if (echoW[mIdx] > 0) begin mState = 2; mCnt = RDLY * 2; end
              else mState = 0;
            end
          end
          2: begin
            mCnt--;
            if (mCnt == 0) begin
              echoDrv[mIdx] = 1'b1;
              mCnt = echoW[mIdx] * 2;
              mState = 3;
            end
          end
          default: begin
            mCnt--;
            if (mCnt == 0) begin
              echoDrv[mIdx] = 1'b0;
              mState = 0;
            end
          end
        endcase
      end
    end
  end

  task automatic waitTrigOf(input int n);
    int start;
    int cyc;
    start = trigOrder.size();
    cyc = 0;
    while (!(trigOrder.size() > start && trigOrder[trigOrder.size() - 1] == n) && cyc < BUDGET) begin
      @(negedge CLK);
      cyc++;
    end
    total++;
    if (cyc >= BUDGET) begin
      bad++;
      $display("[TB] FAIL trigger_timeout sensor=%0d got=none want=trigger within %0d cycles", n, BUDGET);
    end
  endtask

  // Waits for a round to start on SIG1, loads echo widths, and returns when the next round starts.
  task automatic applyRound(input int w1, input int w2, input int w3, input int w4);
    waitTrigOf(1);
    echoW[0] = w1; echoW[1] = w2; echoW[2] = w3; echoW[3] = w4;
    trigOrder.delete();
    waitTrigOf(1);
  endtask

  task automatic applyPublish();
    DEBOUCED_SCLK = 1'b1;
    repeat (6) @(negedge CLK);
    DEBOUCED_SCLK = 1'b0;
    repeat (6) @(negedge CLK);
  endtask

  task automatic test_reset();
    int lat;
    RST_N = 1'b0;
    repeat (10) @(negedge CLK);
    for (int n = 0; n < 4; n++) begin
      total++;
      if (distOut(n) !== 8'd0) begin bad++; $display("[TB] FAIL reset_dist%0d got=%0d want=0", n + 1, distOut(n)); end
      total++;
      if (lineVal(n) !== 1'b0) begin bad++; $display("[TB] FAIL reset_line%0d got=%b want=released", n + 1, lineVal(n)); end
    end
    total++;
    if (ANGLE !== 8'd0 || ANGLE_DIRECTION !== 2'd0) begin
      bad++; $display("[TB] FAIL reset_angle got=%0d/%0d want=0/0", ANGLE, ANGLE_DIRECTION);
    end
    trigOrder.delete();
    trigWidth.delete();
    lat = 0;
    RST_N = 1'b1;
    while (lineVal(0) !== 1'b1 && lat < BUDGET) begin @(negedge CLK); lat++; end
    total++;
    if (lat < 2 * GAP - 2 || lat > 2 * GAP + 6) begin
      bad++; $display("[TB] FAIL first_trigger_latency got=%0d want=%0d..%0d cycles", lat, 2 * GAP - 2, 2 * GAP + 6);
    end
    lat = 0;
    while (trigWidth.size() == 0 && lat < BUDGET) begin @(negedge CLK); lat++; end
    total++;
    if (trigWidth.size() == 0 || trigWidth[0] != 2 * TRIG) begin
      bad++; $display("[TB] FAIL trigger_width got=%0d want=%0d cycles", (trigWidth.size() > 0) ? trigWidth[0] : -1, 2 * TRIG);
    end
    total++;
    if (trigOrder.size() == 0 || trigOrder[0] != 1) begin
      bad++; $display("[TB] FAIL first_sensor got=%0d want=1", (trigOrder.size() > 0) ? trigOrder[0] : 0);
    end
  endtask

  task automatic test_single_echo();
    int w [4];
    int e;
    int g;
    w[0] = 100 * CM + CM / 2;
    for (int n = 1; n < 4; n++) w[n] = randW();
    applyRound(w[0], w[1], w[2], w[3]);
    applyPublish();
    total++;
    if (DISTANCE1_DEBOUNCED !== 8'd100) begin
      bad++; $display("[TB] FAIL single_echo_100cm got=%0d want=100", DISTANCE1_DEBOUNCED);
    end
    for (int n = 1; n < 4; n++) begin
      e = expCm(w[n]);
      total++;
      if (distOut(n) !== 8'(e)) begin bad++; $display("[TB] FAIL single_echo_dist%0d got=%0d want=%0d", n + 1, distOut(n), e); end
    end
    for (int k = 0; k < 4; k++) begin
      g = (k < trigOrder.size()) ? trigOrder[k] : 0;
      total++;
      if (g != (k + 1) % 4 + 1) begin bad++; $display("[TB] FAIL trigger_order slot%0d got=%0d want=%0d", k, g, (k + 1) % 4 + 1); end
    end
  endtask

  task automatic test_no_echo();
    int w [4];
    int e;
    w[0] = randW(); w[1] = randW(); w[2] = 0; w[3] = randW();
    applyRound(w[0], w[1], w[2], w[3]);
    applyPublish();
    for (int n = 0; n < 4; n++) begin
      e = expCm(w[n]);
      total++;
      if (distOut(n) !== 8'(e)) begin bad++; $display("[TB] FAIL no_echo_dist%0d got=%0d want=%0d", n + 1, distOut(n), e); end
    end
  endtask

  task automatic test_saturation();
    int w [4];
    int e;
    w[0] = 1100; w[1] = EMAX + 10; w[2] = randW(); w[3] = randW();
    applyRound(w[0], w[1], w[2], w[3]);
    applyPublish();
    for (int n = 0; n < 4; n++) begin
      e = expCm(w[n]);
      total++;
      if (distOut(n) !== 8'(e)) begin bad++; $display("[TB] FAIL saturation_dist%0d got=%0d want=%0d", n + 1, distOut(n), e); end
    end
  endtask

  task automatic test_angle();
    int d1 [6];
    int d2 [6];
    int ea;
    int ed;
    int w2;
    d1 = '{40, 55, 30, 20, 0, 0};
    d2 = '{55, 40, 30, 255, 0, 0};
    for (int p = 4; p < 6; p++) begin d1[p] = $urandom_range(1, 60); d2[p] = $urandom_range(1, 60); end
    for (int p = 0; p < 6; p++) begin
      w2 = (d2[p] == 255) ? 0 : d2[p] * CM + CM / 2;
      applyRound(d1[p] * CM + CM / 2, w2, randW(), randW());
      applyPublish();
      expAngle(d1[p], d2[p], ea, ed);
      total++;
      if (ANGLE !== 8'(ea)) begin bad++; $display("[TB] FAIL angle_%0d_%0d got=%0d want=%0d", d1[p], d2[p], ANGLE, ea); end
      total++;
      if (ANGLE_DIRECTION !== 2'(ed)) begin bad++; $display("[TB] FAIL angle_dir_%0d_%0d got=%0d want=%0d", d1[p], d2[p], ANGLE_DIRECTION, ed); end
      total++;
      if (DISTANCE2_DEBOUNCED !== 8'(d2[p])) begin bad++; $display("[TB] FAIL angle_dist2 got=%0d want=%0d", DISTANCE2_DEBOUNCED, d2[p]); end
    end
  endtask

  task automatic test_back_to_back();
    int a [4];
    int b [4];
    int e;
    for (int n = 0; n < 4; n++) begin a[n] = randW(); b[n] = randW() + 61 * CM; end
    applyRound(a[0], a[1], a[2], a[3]);
    applyPublish();
    applyRound(b[0], b[1], b[2], b[3]);
    for (int n = 0; n < 4; n++) begin
      e = expCm(a[n]);
      total++;
      if (distOut(n) !== 8'(e)) begin bad++; $display("[TB] FAIL hold_between_edges_dist%0d got=%0d want=%0d", n + 1, distOut(n), e); end
    end
    applyPublish();
    for (int n = 0; n < 4; n++) begin
      e = expCm(b[n]);
      total++;
      if (distOut(n) !== 8'(e)) begin bad++; $display("[TB] FAIL second_publish_dist%0d got=%0d want=%0d", n + 1, distOut(n), e); end
    end
  endtask

  task automatic test_reset_mid_measure();
    int cyc;
    echoW[1] = 200;
    waitTrigOf(2);
    cyc = 0;
    while (!(mState == 3 && mIdx == 1) && cyc < BUDGET) begin @(negedge CLK); cyc++; end
    total++;
    if (cyc >= BUDGET) begin bad++; $display("[TB] FAIL sig2_echo_start got=none want=echo in progress"); end
    repeat (40) @(negedge CLK);
    RST_N = 1'b0;
    repeat (4) @(negedge CLK);
    for (int n = 0; n < 4; n++) begin
      total++;
      if (distOut(n) !== 8'd0) begin bad++; $display("[TB] FAIL midreset_dist%0d got=%0d want=0", n + 1, distOut(n)); end
      total++;
      if (lineVal(n) !== 1'b0) begin bad++; $display("[TB] FAIL midreset_line%0d got=%b want=released", n + 1, lineVal(n)); end
    end
    total++;
    if (ANGLE !== 8'd0 || ANGLE_DIRECTION !== 2'd0) begin
      bad++; $display("[TB] FAIL midreset_angle got=%0d/%0d want=0/0", ANGLE, ANGLE_DIRECTION);
    end
    trigOrder.delete();
    RST_N = 1'b1;
    cyc = 0;
    while (trigOrder.size() == 0 && cyc < BUDGET) begin @(negedge CLK); cyc++; end
    total++;
    if (trigOrder.size() == 0 || trigOrder[0] != 1) begin
      bad++; $display("[TB] FAIL restart_sensor got=%0d want=1", (trigOrder.size() > 0) ? trigOrder[0] : 0);
    end
    // Reset while the DUT itself is driving the trigger must release the line at once.
    RST_N = 1'b0;
    repeat (2) @(negedge CLK);
    total++;
    if (SIG1 !== 1'b0) begin bad++; $display("[TB] FAIL reset_during_trigger got=%b want=released", SIG1); end
    RST_N = 1'b1;
    repeat (4) @(negedge CLK);
  endtask

  initial begin : watchdog
    #2000000;
    $display("[TB] FAIL global_timeout got=still running want=finished");
    $fatal(1, "[TB] simulation time limit reached");
  end

  initial begin : mainSeq
    test_reset();
    test_single_echo();
    test_no_echo();
    test_saturation();
    test_angle();
    test_back_to_back();
    test_reset_mid_measure();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
